// File: rtl/div32_seq.sv
// div32_seq
//   Sequential restoring divider, one quotient bit per clock. Produces
//   LO = quotient and HI = remainder for the HI/LO register path, with a
//   START/BUSY/DONE handshake so the control unit can stall until the result is valid.
//   SIGNED=1 divides two's-complement operands. The quotient truncates toward
//   zero, and the remainder takes the sign of the dividend.
//
//   State   | meaning
//   --------+--------------------------------------------------------------
//   S_IDLE  | waiting for i_start; HI/LO hold the last result
//   S_RUN   | WIDTH shift-subtract iterations on the latched magnitudes
//   S_FIN   | sign fix-up, write HI/LO/DIVZ, pulse DONE
//
// Ports
//   i_clk    clock, rising edge
//   i_rst    asynchronous reset, active high
//   i_start  request, sampled only in S_IDLE
//   i_a      dividend, sampled with i_start
//   i_b      divisor, sampled with i_start
//   o_hi     remainder (registered)
//   o_lo     quotient (registered)
//   o_busy   high in S_RUN and S_FIN
//   o_done   one-cycle pulse, o_hi/o_lo/o_divz valid
//   o_divz   divide-by-zero flag, registered with o_done

module div32_seq #(
    parameter int WIDTH  = 32,
    parameter bit SIGNED = 1'b1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_divz
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_div;
    logic [CW-1:0]    r_cnt;
    logic             r_neg_q;
    logic             r_neg_r;
    logic             r_divz;

    logic             w_a_neg;
    logic             w_b_neg;
    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;
    logic [WIDTH:0]   w_shift;
    logic             w_ge;
    logic [WIDTH-1:0] w_rem_nxt;
    logic [WIDTH-1:0] w_q_final;
    logic [WIDTH-1:0] w_r_final;

    // The magnitude of -2^(WIDTH-1) wraps to itself, which is still correct
    // when the result is read as an unsigned WIDTH-bit number.
    assign w_a_neg = SIGNED & i_a[WIDTH-1];
    assign w_b_neg = SIGNED & i_b[WIDTH-1];
    assign w_a_mag = w_a_neg ? -i_a : i_a;
    assign w_b_mag = w_b_neg ? -i_b : i_b;

    // The shifted partial remainder needs WIDTH+1 bits. After a subtraction the
    // result is below the divisor, so only WIDTH bits are kept.
    assign w_shift   = {r_rem, r_quo[WIDTH-1]};
    assign w_ge      = (w_shift >= {1'b0, r_div});
    assign w_rem_nxt = w_ge ? (w_shift[WIDTH-1:0] - r_div) : w_shift[WIDTH-1:0];

    assign w_q_final = r_neg_q ? -r_quo : r_quo;
    // For a zero divisor every step subtracts nothing, so the remainder is |A|.
    // After the sign fix it equals A as sampled.
    assign w_r_final = r_neg_r ? -r_rem : r_rem;

    assign o_busy = (r_state != S_IDLE);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (i_start) w_state_nxt = S_RUN;
            S_RUN:   if (r_cnt == CW'(1)) w_state_nxt = S_FIN;
            S_FIN:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rem   <= '0;
            r_quo   <= '0;
            r_div   <= '0;
            r_cnt   <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_divz  <= 1'b0;
            o_hi    <= '0;
            o_lo    <= '0;
            o_done  <= 1'b0;
            o_divz  <= 1'b0;
        end else begin
            o_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_rem   <= '0;
                        r_quo   <= w_a_mag;
                        r_div   <= w_b_mag;
                        r_neg_q <= w_a_neg ^ w_b_neg;
                        r_neg_r <= w_a_neg;
                        r_divz  <= (i_b == '0);
                        r_cnt   <= CW'(WIDTH);
                    end
                end
                S_RUN: begin
                    r_rem <= w_rem_nxt;
                    r_quo <= {r_quo[WIDTH-2:0], w_ge};
                    r_cnt <= r_cnt - CW'(1);
                end
                S_FIN: begin
                    o_lo   <= r_divz ? '1 : w_q_final;
                    o_hi   <= w_r_final;
                    o_divz <= r_divz;
                    o_done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div32_seq.sv
module tb_div32_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;
    logic        divz;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [31:0] lo;
        logic [31:0] hi;
        logic        divz;
    } exp_t;

    exp_t scb[$];

    div32_seq #(.WIDTH(32), .SIGNED(1'b1)) dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_start (start),
        .i_a     (a),
        .i_b     (b),
        .o_hi    (hi),
        .o_lo    (lo),
        .o_busy  (busy),
        .o_done  (done),
        .o_divz  (divz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t model(input logic [31:0] va, input logic [31:0] vb);
        exp_t   e;
        longint sa;
        longint sb;
        longint q;
        longint r;
        if (vb == 32'd0) begin
            e.lo   = 32'hffff_ffff;
            e.hi   = va;
            e.divz = 1'b1;
        end else begin
            sa     = longint'($signed(va));
            sb     = longint'($signed(vb));
            q      = sa / sb;
            r      = sa % sb;
            e.lo   = q[31:0];
            e.hi   = r[31:0];
            e.divz = 1'b0;
        end
        return e;
    endfunction

    // Drives one START cycle and records the expected result. Returns just
    // after the accepting edge (edge 0).
    task automatic start_op(input logic [31:0] va, input logic [31:0] vb);
        @(negedge clk);
        a     = va;
        b     = vb;
        start = 1'b1;
        scb.push_back(model(va, vb));
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(output int lat, output bit got);
        lat = 0;
        got = 1'b0;
        for (int k = 1; k <= 60 && !got; k++) begin
            @(posedge clk);
            #1;
            if (done) begin
                got = 1'b1;
                lat = k;
            end
        end
    endtask

    task automatic test_reset;
        rst   = 1'b1;
        start = 1'b1;
        a     = 32'd9;
        b     = 32'd3;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++;
        if (divz !== 1'b0) begin errors++; $display("FAIL reset_divz got=%b exp=0", divz); end
        checks++;
        if (hi !== 32'd0) begin errors++; $display("FAIL reset_hi got=%h exp=0", hi); end
        checks++;
        if (lo !== 32'd0) begin errors++; $display("FAIL reset_lo got=%h exp=0", lo); end
        start = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy got=%b exp=0", busy); end
    endtask

    task automatic test_vectors;
        logic [31:0] ta [12];
        logic [31:0] tbv[12];
        int          lat;
        bit          got;
        exp_t        e;
        ta[0]  = 32'd7;          tbv[0]  = 32'd2;
        ta[1]  = 32'hffff_fff9;  tbv[1]  = 32'd2;
        ta[2]  = 32'hffff_fff6;  tbv[2]  = 32'hffff_fffb;
        ta[3]  = 32'hffff_fff4;  tbv[3]  = 32'd2;
        ta[4]  = 32'h8000_0000;  tbv[4]  = 32'hffff_ffff;
        ta[5]  = 32'd5;          tbv[5]  = 32'd0;
        ta[6]  = 32'h7fff_ffff;  tbv[6]  = 32'd1;
        ta[7]  = 32'd17;         tbv[7]  = 32'hffff_fffb;
        ta[8]  = 32'd3;          tbv[8]  = 32'd10;
        ta[9]  = 32'hffff_ffec;  tbv[9]  = 32'd0;
        ta[10] = $urandom;       tbv[10] = $urandom;
        ta[11] = $urandom;       tbv[11] = $urandom_range(1, 1000);
        for (int i = 0; i < 12; i++) begin
            start_op(ta[i], tbv[i]);
            wait_done(lat, got);
            checks++;
            if (!got || lat != 33) begin
                errors++;
                $display("FAIL latency[%0d] got=%0d seen=%0b exp=33", i, lat, got);
            end
            e = scb.pop_front();
            checks++;
            if (lo !== e.lo) begin errors++; $display("FAIL lo[%0d] a=%h b=%h got=%h exp=%h", i, ta[i], tbv[i], lo, e.lo); end
            checks++;
            if (hi !== e.hi) begin errors++; $display("FAIL hi[%0d] a=%h b=%h got=%h exp=%h", i, ta[i], tbv[i], hi, e.hi); end
            checks++;
            if (divz !== e.divz) begin errors++; $display("FAIL divz[%0d] got=%b exp=%b", i, divz, e.divz); end
            @(posedge clk);
            #1;
            checks++;
            if (done !== 1'b0) begin errors++; $display("FAIL done_width[%0d] got=%b exp=0", i, done); end
        end
    endtask

    task automatic test_ignore_start;
        int   busy_bad  = 0;
        int   done_cnt  = 0;
        int   done_edge = -1;
        exp_t e;
        start_op(32'd7, 32'd2);
        if (busy !== 1'b1) busy_bad++;
        for (int k = 1; k <= 36; k++) begin
            if (k == 10) begin
                @(negedge clk);
                a     = 32'd100;
                b     = 32'd3;
                start = 1'b1;
            end
            @(posedge clk);
            #1;
            if (k == 10) start = 1'b0;
            if (busy !== (k <= 32)) busy_bad++;
            if (done) begin
                done_cnt++;
                if (done_edge < 0) done_edge = k;
                if (done_cnt == 1) begin
                    e = scb.pop_front();
                    checks++;
                    if (lo !== e.lo) begin errors++; $display("FAIL ignore_lo got=%h exp=%h", lo, e.lo); end
                    checks++;
                    if (hi !== e.hi) begin errors++; $display("FAIL ignore_hi got=%h exp=%h", hi, e.hi); end
                end
            end
        end
        checks++;
        if (busy_bad != 0) begin errors++; $display("FAIL busy_window bad_cycles=%0d exp=0", busy_bad); end
        checks++;
        if (done_cnt != 1) begin errors++; $display("FAIL done_count got=%0d exp=1", done_cnt); end
        checks++;
        if (done_edge != 33) begin errors++; $display("FAIL done_edge got=%0d exp=33", done_edge); end
        if (done_cnt == 0) void'(scb.pop_front());
    endtask

    task automatic test_reset_mid;
        int   lat;
        bit   got;
        exp_t e;
        start_op(32'd1000, 32'd7);
        for (int k = 1; k <= 15; k++) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got=%b exp=0", busy); end
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL abort_done got=%b exp=0", done); end
        checks++;
        if (hi !== 32'd0) begin errors++; $display("FAIL abort_hi got=%h exp=0", hi); end
        checks++;
        if (lo !== 32'd0) begin errors++; $display("FAIL abort_lo got=%h exp=0", lo); end
        void'(scb.pop_front());
        @(negedge clk);
        rst = 1'b0;
        wait_done(lat, got);
        checks++;
        if (got) begin errors++; $display("FAIL abort_no_done got=1 exp=0 at cycle %0d", lat); end
        start_op(32'hffff_ffff, 32'd1);
        wait_done(lat, got);
        checks++;
        if (!got || lat != 33) begin errors++; $display("FAIL post_abort_latency got=%0d exp=33", lat); end
        e = scb.pop_front();
        checks++;
        if (lo !== e.lo) begin errors++; $display("FAIL post_abort_lo got=%h exp=%h", lo, e.lo); end
        checks++;
        if (hi !== e.hi) begin errors++; $display("FAIL post_abort_hi got=%h exp=%h", hi, e.hi); end
    endtask

    task automatic test_back_to_back;
        int   lat;
        bit   got;
        exp_t e;
        start_op(32'd20, 32'd6);
        for (int k = 1; k <= 32; k++) @(posedge clk);
        // START is held over the FIN edge (must be ignored) and the next edge (accepted).
        @(negedge clk);
        a     = 32'd50;
        b     = 32'd7;
        start = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (done !== 1'b1) begin errors++; $display("FAIL b2b_first_done got=%b exp=1", done); end
        e = scb.pop_front();
        checks++;
        if (lo !== e.lo || hi !== e.hi) begin
            errors++;
            $display("FAIL b2b_first got=%h/%h exp=%h/%h", lo, hi, e.lo, e.hi);
        end
        scb.push_back(model(32'd50, 32'd7));
        @(posedge clk);
        #1 start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL b2b_accept busy=%b exp=1", busy); end
        wait_done(lat, got);
        checks++;
        if (!got || lat != 33) begin errors++; $display("FAIL b2b_latency got=%0d exp=33", lat); end
        e = scb.pop_front();
        checks++;
        if (lo !== e.lo || hi !== e.hi) begin
            errors++;
            $display("FAIL b2b_second got=%h/%h exp=%h/%h", lo, hi, e.lo, e.hi);
        end
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        test_reset();
        test_vectors();
        test_ignore_start();
        test_reset_mid();
        test_back_to_back();
        checks++;
        if (scb.size() != 0) begin errors++; $display("FAIL scoreboard_left got=%0d exp=0", scb.size()); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
